// File: rtl/traffic_lane_scheduler.sv
// traffic_lane_scheduler: round-robin respawn arbiter that grants one vehicle per frame a free lane
//
// Ports:
//   clk          pixel clock
//   resetN       synchronous active-low reset
//   frame_start  one-cycle pulse per frame
//   random       free-running random value, bits [1:0] seed the lane search
//   respawn_req  per-vehicle level request, held until its ack
//   ack          one-hot grant pulse to the winning vehicle
//   spawn_valid  high for the grant cycle only
//   spawn_id     index of the granted vehicle
//   spawn_x      left x of the assigned lane
//   lane_busy    lane occupancy bitmap
//   busy         high whenever the FSM is not idle
//
// Build option: define SPAWN_COOLDOWN_EN to enforce SPAWN_GAP_FRAMES idle frames after each grant.
module traffic_lane_scheduler #(
    parameter int          NUM_VEHICLES = 4,
    parameter logic [10:0] LANE_X0      = 11'd140,
    parameter logic [10:0] LANE_X1      = 11'd180,
    parameter logic [10:0] LANE_X2      = 11'd220,
    parameter logic [10:0] LANE_X3      = 11'd260
`ifdef SPAWN_COOLDOWN_EN
    ,
    parameter int          SPAWN_GAP_FRAMES = 3
`endif
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    frame_start,
    input  logic [10:0]             random,
    input  logic [NUM_VEHICLES-1:0] respawn_req,
    output logic [NUM_VEHICLES-1:0] ack,
    output logic                    spawn_valid,
    output logic [1:0]              spawn_id,
    output logic [10:0]             spawn_x,
    output logic [3:0]              lane_busy,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, ARB, PICK, GRANT} state_t;

    state_t      state;
    logic [1:0]  cand, winner, lane, scan, rr_ptr, win, idx;
    logic [3:0]  req, owner_valid;
    logic [1:0]  owner_lane [4];
    logic        found, hold, unused_random;

    assign req           = 4'(respawn_req);
    assign unused_random = ^random[10:2];

`ifdef SPAWN_COOLDOWN_EN
    logic [7:0] cooldown;
    assign hold = cooldown != 8'd0;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [10:0] lane_x(input logic [1:0] l);
        return l == 2'd0 ? LANE_X0 : l == 2'd1 ? LANE_X1 : l == 2'd2 ? LANE_X2 : LANE_X3;
    endfunction

    // Descending scan so the last hit is the closest requester at or above rr_ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_VEHICLES - 1; k >= 0; k--) begin
            idx = 2'((int'(rr_ptr) + k) % NUM_VEHICLES);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            cand        <= '0;
            winner      <= '0;
            lane        <= '0;
            scan        <= '0;
            rr_ptr      <= '0;
            owner_valid <= '0;
            owner_lane  <= '{default: 2'd0};
            lane_busy   <= '0;
            ack         <= '0;
            spawn_valid <= 1'b0;
            spawn_id    <= '0;
            spawn_x     <= '0;
            busy        <= 1'b0;
`ifdef SPAWN_COOLDOWN_EN
            cooldown    <= '0;
`endif
        end else begin
            ack         <= '0;
            spawn_valid <= 1'b0;
            spawn_id    <= '0;
            spawn_x     <= '0;
            case (state)
                IDLE: if (frame_start) begin
                    if (hold) begin
`ifdef SPAWN_COOLDOWN_EN
                        cooldown <= cooldown - 8'd1;
`endif
                    end else begin
                        cand <= random[1:0];
                        if (|req) begin
                            state <= ARB;
                            busy  <= 1'b1;
                        end
                    end
                end
                ARB: if (found) begin
                    // The winner gives up its old lane before the search so it may land back on it.
                    winner <= win;
                    if (owner_valid[win]) lane_busy[owner_lane[win]] <= 1'b0;
                    owner_valid[win] <= 1'b0;
                    scan  <= '0;
                    state <= PICK;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                PICK: if (!lane_busy[cand]) begin
                    lane        <= cand;
                    state       <= GRANT;
                    ack         <= NUM_VEHICLES'(4'b0001 << winner);
                    spawn_valid <= 1'b1;
                    spawn_id    <= winner;
                    spawn_x     <= lane_x(cand);
                end else if (scan == 2'd3) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    cand <= cand + 2'd1;
                    scan <= scan + 2'd1;
                end
                GRANT: begin
                    lane_busy[lane]     <= 1'b1;
                    owner_lane[winner]  <= lane;
                    owner_valid[winner] <= 1'b1;
                    rr_ptr <= 2'((int'(winner) + 1) % NUM_VEHICLES);
`ifdef SPAWN_COOLDOWN_EN
                    cooldown <= 8'(SPAWN_GAP_FRAMES);
`endif
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_lane_scheduler.sv
// tb_traffic_lane_scheduler: randomized frame-level check of traffic_lane_scheduler against a lane-ownership model
module tb_traffic_lane_scheduler;
    localparam int N = 4;
`ifdef SPAWN_COOLDOWN_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 0;
`endif

    logic          clk = 1'b0, resetN = 1'b0, frame_start = 1'b0;
    logic [10:0]   random = '0;
    logic [N-1:0]  respawn_req = '0;
    logic [N-1:0]  ack;
    logic          spawn_valid, busy;
    logic [1:0]    spawn_id;
    logic [10:0]   spawn_x;
    logic [3:0]    lane_busy;

    traffic_lane_scheduler #(.NUM_VEHICLES(N)) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start), .random(random),
        .respawn_req(respawn_req), .ack(ack), .spawn_valid(spawn_valid),
        .spawn_id(spawn_id), .spawn_x(spawn_x), .lane_busy(lane_busy), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int owner [4];
    int rr, cool;
    bit last_granted;
    int lx [4] = '{140, 180, 220, 260};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] occ();
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) if (owner[i] >= 0) m[owner[i]] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) owner[i] = -1;
        rr   = 0;
        cool = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN      = 1'b0;
        respawn_req = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        model_reset();
    endtask

    // One frame: predict the whole transaction from lane ownership, then watch 7 cycles.
    task automatic frame(input logic [1:0] c, input bit hold_req, input bit extra, input bit drop, input bit rst_pick);
        bit active = 0, granted = 0, stop = 0;
        int w = 0, lane = 0, gj = -1, fin = 0;
        logic [3:0] l0, l1, l2, eb;
        logic       ev;
        l0 = occ();
        l1 = l0;
        l2 = l0;
        if (cool > 0) cool--;
        else if (respawn_req != 0) begin
            active = 1;
            for (int i = N - 1; i >= 0; i--) if (respawn_req[(rr + i) % N]) w = (rr + i) % N;
            owner[w] = -1;
            l1 = occ();
            for (int i = 3; i >= 0; i--)
                if (!l1[(c + i) % 4]) begin
                    lane    = (c + i) % 4;
                    gj      = 3 + i;
                    granted = 1;
                end
            fin = granted ? gj + 1 : 6;
            if (granted) begin
                owner[w] = lane;
                rr       = (w + 1) % N;
                cool     = GAP;
            end
            l2 = occ();
        end
        last_granted = granted;
        @(negedge clk);
        random      = {9'($urandom), c};
        frame_start = 1'b1;
        for (int j = 1; j <= 7 && !stop; j++) begin
            @(negedge clk);
            if (rst_pick && j == 3) begin
                check("rst_ack", 32'(ack), 0);
                check("rst_valid", 32'(spawn_valid), 0);
                check("rst_lane_busy", 32'(lane_busy), 0);
                check("rst_busy", 32'(busy), 0);
                resetN = 1'b1;
                model_reset();
                last_granted = 0;
                stop = 1;
            end else begin
                ev = granted && j == gj;
                eb = !active || j < 2 ? l0 : (granted && j > gj) ? l2 : l1;
                check("spawn_valid", 32'(spawn_valid), 32'(ev));
                check("ack", 32'(ack), ev ? 32'(1 << w) : 0);
                check("spawn_id", 32'(spawn_id), ev ? 32'(w) : 0);
                check("spawn_x", 32'(spawn_x), ev ? 32'(lx[lane]) : 0);
                check("busy", 32'(busy), 32'(active && j < fin));
                check("lane_busy", 32'(lane_busy), 32'(eb));
                frame_start = extra && active && j == 2;
                random      = 11'($urandom);
                if (drop && granted && j == 2) respawn_req[w] = 1'b0;
                if (rst_pick && j == 2) resetN = 1'b0;
            end
        end
        frame_start = 1'b0;
        if (granted && !hold_req) respawn_req[w] = 1'b0;
    endtask

    task automatic grant_dir(input logic [N-1:0] r, input logic [1:0] c);
        respawn_req  = r;
        last_granted = 0;
        for (int t = 0; t < 8 && !last_granted; t++) frame(c, 0, 0, 0, 0);
        check("grant_timeout", 32'(last_granted), 1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 0);
        check("reset_valid", 32'(spawn_valid), 0);
        check("reset_x", 32'(spawn_x), 0);
        check("reset_lane_busy", 32'(lane_busy), 0);
        check("reset_busy", 32'(busy), 0);
        resetN = 1'b1;

        // single request, lane 2 free
        grant_dir(4'b0001, 2'd2);

        // winner's own lane released, two busy lanes skipped, wrap to lane 0
        do_reset();
        grant_dir(4'b0001, 2'd1);
        grant_dir(4'b0010, 2'd2);
        grant_dir(4'b0100, 2'd3);
        grant_dir(4'b0001, 2'd2);

        // extra frame_start while busy is ignored
        grant_dir(4'b1000, 2'd0);
        respawn_req = 4'b0110;
        repeat (GAP + 1) frame(2'd1, 0, 1, 0, 0);

        // reset during PICK aborts the grant
        do_reset();
        respawn_req = 4'b0001;
        frame(2'd0, 1, 0, 0, 1);

        // all requests held: round-robin with cooldown spacing
        do_reset();
        respawn_req = 4'b1111;
        repeat (13) frame(2'($urandom), 1, 0, 0, 0);

        // held pair: consecutive grants when no cooldown
        do_reset();
        respawn_req = 4'b0011;
        repeat (4) frame(2'($urandom), 1, 0, 0, 0);

        // randomized traffic
        do_reset();
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 2) == 0) respawn_req = respawn_req | N'($urandom);
            frame(2'($urandom), 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
